// File: rtl/lut_activation_scheduler_if.sv
// Bundle of the requester, response and shared-LUT signals of one activation scheduler.
// The slave modport is the scheduler's view; master is the surrounding layer's view.
interface lut_activation_scheduler_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int FRAC_W = 4
);
   logic [NREQ-1:0]                 req;
   logic [NREQ*(ADDR_W+FRAC_W)-1:0] req_x;
   logic [NREQ-1:0]                 grant;
   logic [ADDR_W-1:0]               lut_address;
   logic [DATA_W-1:0]               lut_base;
   logic [DATA_W-1:0]               lut_next;
   logic [NREQ-1:0]                 resp_valid;
   logic [DATA_W-1:0]               resp_data;
   logic                            resp_ready;
   logic                            busy;

   modport slave (
      input  req, req_x, lut_base, lut_next, resp_ready,
      output grant, lut_address, resp_valid, resp_data, busy
   );

   modport master (
      output req, req_x, lut_base, lut_next, resp_ready,
      input  grant, lut_address, resp_valid, resp_data, busy
   );
endinterface

// File: rtl/lut_activation_scheduler.sv
// Round-robin scheduler sharing one activation LUT among NREQ neurons, with
// piecewise-linear interpolation between adjacent LUT entries and saturation.
module lut_activation_scheduler #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int FRAC_W = 4
) (
   input  logic clk,
   input  logic rst,
   lut_activation_scheduler_if.slave bus
);
   localparam int x_w    = ADDR_W + FRAC_W;
   localparam int id_w   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int prod_w = DATA_W + FRAC_W + 2;
   localparam int sum_w  = prod_w + 1;
   localparam logic signed [sum_w-1:0] sat_max = sum_w'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [sum_w-1:0] sat_min = sum_w'(-(2 ** (DATA_W - 1)));

   typedef enum logic [1:0] {idle, lookup, interp, resp} state_t;

   state_t                     state_reg, state_next;
   logic [id_w-1:0]            rr_ptr_reg;
   logic [id_w-1:0]            id_reg;
   logic [ADDR_W-1:0]          addr_reg;
   logic [FRAC_W-1:0]          frac_reg;
   logic signed [DATA_W-1:0]   base_reg;
   logic signed [DATA_W-1:0]   next_reg;
   logic [DATA_W-1:0]          resp_data_reg;

   logic [x_w-1:0]             x_slice [NREQ];
   logic [x_w-1:0]             x_pick;
   logic                       pick_found;
   logic [id_w-1:0]            pick_id;

   logic signed [DATA_W:0]     diff;
   logic signed [prod_w-1:0]   prod;
   logic signed [prod_w-1:0]   shifted;
   logic signed [sum_w-1:0]    y_sum;
   logic [DATA_W-1:0]          y_sat;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign x_slice[gi] = bus.req_x[gi*x_w +: x_w];
      end
   endgenerate

   // First requester strictly after the last one served, wrapping around.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!pick_found && bus.req[(int'(rr_ptr_reg) + k) % NREQ]) begin
            pick_found = 1'b1;
            pick_id    = id_w'((int'(rr_ptr_reg) + k) % NREQ);
         end
      end
   end

   assign x_pick = x_slice[pick_id];

   // Arithmetic shift floors toward -inf; the wide sum cannot overflow before clamping.
   always_comb begin
      diff    = (DATA_W+1)'(next_reg) - (DATA_W+1)'(base_reg);
      prod    = prod_w'(diff) * prod_w'($signed({1'b0, frac_reg}));
      shifted = prod >>> FRAC_W;
      y_sum   = sum_w'(base_reg) + sum_w'(shifted);
      if (y_sum > sat_max) begin
         y_sat = sat_max[DATA_W-1:0];
      end else if (y_sum < sat_min) begin
         y_sat = sat_min[DATA_W-1:0];
      end else begin
         y_sat = y_sum[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= idle;
         rr_ptr_reg    <= id_w'(NREQ - 1);
         id_reg        <= '0;
         addr_reg      <= '0;
         frac_reg      <= '0;
         base_reg      <= '0;
         next_reg      <= '0;
         resp_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            idle: begin
               if (pick_found) begin
                  id_reg   <= pick_id;
                  addr_reg <= x_pick[x_w-1:FRAC_W];
                  frac_reg <= x_pick[FRAC_W-1:0];
               end
            end
            lookup: begin
               base_reg <= bus.lut_base;
               next_reg <= bus.lut_next;
            end
            interp: resp_data_reg <= y_sat;
            resp: begin
               if (bus.resp_ready) begin
                  rr_ptr_reg <= id_reg;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         idle:    if (pick_found) state_next = lookup;
         lookup:  state_next = interp;
         interp:  state_next = resp;
         resp:    if (bus.resp_ready) state_next = idle;
         default: state_next = idle;
      endcase
   end

   always_comb begin
      bus.grant       = '0;
      bus.resp_valid  = '0;
      bus.busy        = (state_reg != idle);
      bus.lut_address = addr_reg;
      bus.resp_data   = resp_data_reg;
      if (state_reg == idle && pick_found) begin
         bus.grant = NREQ'(1) << pick_id;
      end
      if (state_reg == resp) begin
         bus.resp_valid = NREQ'(1) << id_reg;
      end
   end
endmodule

// File: tb/tb_lut_activation_scheduler.sv
// Directed bench for lut_activation_scheduler: LUT model, response scoreboard,
// latency, round-robin order, backpressure, saturation and mid-flight reset.
module tb_lut_activation_scheduler;
   localparam int NREQ = 4;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   lut_a;
   logic       stub_en = 1'b0;
   logic [7:0] stub_base = '0;
   logic [7:0] stub_next = '0;
   exp_t sb_q[$];
   int   g_id_q[$];
   int   g_cyc_q[$];

   lut_activation_scheduler_if #(.NREQ(4), .DATA_W(8), .ADDR_W(4), .FRAC_W(4)) bus ();

   lut_activation_scheduler #(.NREQ(4), .DATA_W(8), .ADDR_W(4), .FRAC_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Entries 0..7 rise 0..112, entries 8..15 run -128..-16; address 7 clamps onto itself.
   function automatic logic [7:0] lut_val(input int a);
      int v;
      v = (a < 8) ? 16 * a : -128 + 16 * (a - 8);
      return 8'(v);
   endfunction

   always_comb begin
      lut_a = int'(bus.lut_address);
      if (stub_en) begin
         bus.lut_base = stub_base;
         bus.lut_next = stub_next;
      end else begin
         bus.lut_base = lut_val(lut_a);
         bus.lut_next = (lut_a == 7) ? lut_val(7) : lut_val((lut_a + 1) % 16);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_x(input int id, input logic [7:0] x);
      bus.req_x[id*8 +: 8] = x;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         #3;
         if (!bus.busy && sb_q.size() == 0) begin
            done = 1;
            break;
         end
      end
      check("idle_timeout", 32'(done), 1);
   endtask

   task automatic run_one(input int id, input logic [7:0] x, input logic [7:0] exp_data);
      bit got = 0;
      tick();
      bus.req[id] = 1'b1;
      set_x(id, x);
      sb_q.push_back('{id, exp_data});
      for (int i = 0; i < 20; i++) begin
         #1;
         if (bus.grant[id]) begin
            got = 1;
            break;
         end
         tick();
      end
      check("grant_timeout", 32'(got), 1);
      tick();
      bus.req[id] = 1'b0;
      wait_idle();
   endtask

   // Monitor: exclusivity every cycle, grant log, scoreboard pop on each handshake.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         check("grant_onehot", 32'($onehot0(bus.grant)), 1);
         check("valid_onehot", 32'($onehot0(bus.resp_valid)), 1);
         check("grant_valid_excl", 32'((|bus.grant) && (|bus.resp_valid)), 0);
         if (bus.grant != '0) begin
            for (int b = 0; b < NREQ; b++) begin
               if (bus.grant[b]) begin
                  g_id_q.push_back(b);
                  g_cyc_q.push_back(cyc);
               end
            end
         end
         if (rst && bus.resp_valid != '0 && bus.resp_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_resp", 32'(bus.resp_valid), 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("resp_id", 32'(bus.resp_valid), 32'(1 << e.id));
               check("resp_data", 32'(bus.resp_data), 32'(e.data));
               $display("resp id=%0d data=%0d expected=%0d", e.id,
                        $signed(bus.resp_data), $signed(e.data));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      rst            = 1'b0;
      bus.req        = '0;
      bus.req_x      = '0;
      bus.resp_ready = 1'b1;

      // Reset state
      tick();
      #1;
      check("rst_grant", 32'(bus.grant), 0);
      check("rst_valid", 32'(bus.resp_valid), 0);
      check("rst_data", 32'(bus.resp_data), 0);
      check("rst_addr", 32'(bus.lut_address), 0);
      check("rst_busy", 32'(bus.busy), 0);
      tick();
      rst = 1'b1;

      // Single request: grant at T, address at T+1, response at T+3
      tick();
      bus.req = 4'b0001;
      set_x(0, 8'h25);
      sb_q.push_back('{0, 8'd37});
      #1;
      check("t0_grant", 32'(bus.grant), 32'h1);
      tick();
      bus.req = '0;
      #1;
      check("t1_addr", 32'(bus.lut_address), 2);
      check("t1_grant", 32'(bus.grant), 0);
      check("t1_busy", 32'(bus.busy), 1);
      tick();
      #1;
      check("t2_valid", 32'(bus.resp_valid), 0);
      tick();
      #1;
      check("t3_valid", 32'(bus.resp_valid), 32'h1);
      check("t3_data", 32'(bus.resp_data), 37);
      tick();
      #1;
      check("t4_valid", 32'(bus.resp_valid), 0);
      check("t4_busy", 32'(bus.busy), 0);

      // Clamp at top entry, wrap from entry 15 to entry 0, frac=0 with default LUT
      run_one(1, 8'h7A, 8'd112);
      run_one(2, 8'hF8, 8'hF8);
      run_one(3, 8'h30, 8'd48);

      // Saturation-range stub LUT; floor rounding must give -113 not -112
      stub_en   = 1'b1;
      stub_base = 8'd120;
      stub_next = 8'h80;
      run_one(0, 8'h0F, 8'h8F);
      run_one(1, 8'h00, 8'd120);
      stub_base = 8'h80;
      stub_next = 8'h7F;
      run_one(2, 8'h0F, 8'h6F);
      stub_en = 1'b0;

      // Backpressure: response held 5 extra cycles, req[1] waits
      bus.resp_ready = 1'b0;
      tick();
      bus.req = 4'b0001;
      set_x(0, 8'h25);
      sb_q.push_back('{0, 8'd37});
      #1;
      check("bp_grant0", 32'(bus.grant), 32'h1);
      tick();
      bus.req = 4'b0010;
      set_x(1, 8'h48);
      sb_q.push_back('{1, 8'h48});
      #1;
      check("bp_busy_grant", 32'(bus.grant), 0);
      tick();
      tick();
      #1;
      check("bp_valid", 32'(bus.resp_valid), 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         check("bp_hold_valid", 32'(bus.resp_valid), 32'h1);
         check("bp_hold_data", 32'(bus.resp_data), 37);
         check("bp_hold_grant", 32'(bus.grant), 0);
      end
      tick();
      bus.resp_ready = 1'b1;
      #1;
      check("bp_hs_grant", 32'(bus.grant), 0);
      tick();
      #1;
      check("bp_next_grant", 32'(bus.grant), 32'h2);
      tick();
      bus.req = '0;
      wait_idle();

      // Reset during INTERP aborts the transaction; rr pointer restarts at NREQ-1
      tick();
      bus.req = 4'b0100;
      set_x(2, 8'h33);
      #1;
      check("ra_grant", 32'(bus.grant), 32'h4);
      tick();
      bus.req = '0;
      tick();
      rst = 1'b0;
      #1;
      check("ra_grant0", 32'(bus.grant), 0);
      check("ra_valid0", 32'(bus.resp_valid), 0);
      check("ra_data0", 32'(bus.resp_data), 0);
      check("ra_addr0", 32'(bus.lut_address), 0);
      check("ra_busy0", 32'(bus.busy), 0);
      tick();
      rst     = 1'b1;
      bus.req = 4'b1010;
      set_x(1, 8'h25);
      set_x(3, 8'h7A);
      sb_q.push_back('{1, 8'd37});
      sb_q.push_back('{3, 8'd112});
      #1;
      check("ra_first_grant", 32'(bus.grant), 32'h2);
      tick();
      bus.req = 4'b1000;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         #1;
         if (bus.grant[3]) begin
            got = 1;
            break;
         end
      end
      check("ra_grant3_timeout", 32'(got), 1);
      tick();
      bus.req = '0;
      wait_idle();

      // Round-robin with all four requesting continuously
      tick();
      g_id_q.delete();
      g_cyc_q.delete();
      set_x(0, 8'h25);
      set_x(1, 8'h7A);
      set_x(2, 8'hF8);
      set_x(3, 8'h48);
      sb_q.push_back('{0, 8'd37});
      sb_q.push_back('{1, 8'd112});
      sb_q.push_back('{2, 8'hF8});
      sb_q.push_back('{3, 8'h48});
      sb_q.push_back('{0, 8'd37});
      bus.req = 4'b1111;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         #3;
         if (g_id_q.size() >= 5) begin
            got = 1;
            break;
         end
      end
      tick();
      bus.req = '0;
      check("rr_timeout", 32'(got), 1);
      if (got) begin
         for (int i = 0; i < 5; i++) begin
            check("rr_order", 32'(g_id_q[i]), 32'(i % 4));
            $display("rr grant %0d id=%0d cyc=%0d", i, g_id_q[i], g_cyc_q[i]);
         end
         for (int i = 1; i < 5; i++) begin
            check("rr_spacing", 32'(g_cyc_q[i] - g_cyc_q[i-1]), 4);
         end
      end
      wait_idle();
      check("sb_drained", 32'(sb_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lut_activation_scheduler.md
Name: lut_activation_scheduler

Overview:
- Shares one 16-entry activation LUT (4-bit address in; combinational `base` and `next__data` out) among NREQ neuron requesters.
- Per request: round-robin arbitration, LUT lookup, then piecewise-linear interpolation between `base` and `next__data` using the input's low fraction bits.
- Returns the activated value to the granted neuron over a valid/ready handshake.
- Sits in each layer between the neuron accumulators and the shared activation LUT instance.

Parameters:
- NREQ, 4, number of requesting neurons.
- DATA_W, 8, signed width of LUT entries and of the result.
- ADDR_W, 4, LUT address width (upper ADDR_W bits of the input).
- FRAC_W, 4, unsigned fraction width (lower FRAC_W bits of the input); input width is ADDR_W+FRAC_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-neuron request; must be held until its grant bit pulses.
- req_x  in  NREQ*(ADDR_W+FRAC_W)  packed signed pre-activation values; slice i belongs to req[i].
- grant  out  NREQ  one-hot, one-cycle pulse; req_x[i] is sampled in that cycle.
- lut_address  out  ADDR_W  address to the shared LUT.
- lut_base  in  DATA_W  LUT `base` (signed).
- lut_next  in  DATA_W  LUT `next__data` (signed).
- resp_valid  out  NREQ  one-hot response valid.
- resp_data  out  DATA_W  signed activated value.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; grant, resp_valid, resp_data, lut_address, busy = 0; rr_ptr=NREQ-1, so req[0] has top priority after reset. Reset mid-operation aborts the transaction, and no response is issued for it.
- FSM: IDLE -> LOOKUP -> INTERP -> RESP -> IDLE.
- IDLE, with any req bit high:
  - Pick the first set bit searching from rr_ptr+1 upward, wrapping modulo NREQ.
  - Assert that grant bit this cycle.
  - Register id, addr = x[ADDR_W+FRAC_W-1:FRAC_W] and frac = x[FRAC_W-1:0].
  - Go to LOOKUP.
  - With no req, stay in IDLE; grant=0.
- LOOKUP: lut_address = registered addr (held stable from LOOKUP through RESP). Register lut_base and lut_next; go to INTERP.
- INTERP:
  - diff = next - base, signed DATA_W+1 bits.
  - prod = diff * {0,frac}, signed DATA_W+FRAC_W+2 bits.
  - y = base + (prod >>> FRAC_W), arithmetic shift, truncating toward -inf.
  - Saturate y to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register the result into resp_data; go to RESP.
- RESP:
  - resp_valid[id]=1; resp_data is stable while waiting.
  - When resp_ready=1, the transfer completes in that cycle: rr_ptr<=id, state<=IDLE, resp_valid drops the next cycle.
  - resp_ready is ignored outside RESP.
- Latency: grant cycle T; resp_valid first high at T+3. Minimum 4 cycles per transaction. The next grant occurs no earlier than the cycle after the handshake.
- No pipelining: one transaction in flight.
- Requests that arrive while busy wait; req changes during busy are ignored.
- Deasserting req before grant withdraws the request.
- The LUT's own wrap (address max -> entry 0) and clamp (address 2^(ADDR_W-1)-1 -> same entry) need no special-casing; the arithmetic above covers them.
- frac=0 yields exactly base.
- Fairness: a continuously requesting neuron is regranted only after every other active requester has been served once.
- grant and resp_valid are each one-hot or zero at all times; they are never high in the same cycle.

Test Plan:
- Single request, req[0]=1, x=0x25 (LUT entries 32 at addr 2, 48 at addr 3) -> grant[0] at T; lut_address=2 at T+1; resp_valid[0]=1 and resp_data=37 at T+3.
- Clamp: x=0x7A (base=next=112) -> resp_data=112; wrap: x=0xF8 (base=-16, next=0, frac=8) -> resp_data=-8.
- Round-robin: req=4'b1111 held continuously, resp_ready=1 -> grants in order 0,1,2,3,0, spaced 4 cycles apart, each response routed to the matching resp_valid bit.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data hold; req[1] pending gets no grant until the cycle after resp_ready=1.
- Saturation, with a stub LUT base=120, next=-128 (diff=-248) or base=-128, next=127, frac=15 -> result stays within [-128,127] with no wrap-around.
- Reset asserted in INTERP -> all outputs 0 immediately; after release, req=4'b1010 -> grant[1] first (rr_ptr reset to 3).
